// File: rtl/sd_pkg.sv
// Shared constants, error codes and state encoding for the SD single-block reader.
package sd_pkg;

   localparam logic [6:0]  CMD17      = 7'd17;
   localparam logic [7:0]  TOK_START  = 8'hFE;
   localparam logic [7:0]  TOK_IDLE   = 8'hFF;

   localparam logic [2:0]  ERR_OK       = 3'd0;
   localparam logic [2:0]  ERR_R1       = 3'd1;
   localparam logic [2:0]  ERR_TIMEOUT  = 3'd2;
   localparam logic [2:0]  ERR_DATA_TOK = 3'd3;
   localparam logic [2:0]  ERR_CRC      = 3'd4;

   localparam logic [15:0] CRC16_POLY = 16'h1021;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_RESP  = 3'd2,
      ST_TOKEN = 3'd3,
      ST_DATA  = 3'd4,
      ST_CRC   = 3'd5,
      ST_FIN   = 3'd6
   } state_t;

endpackage

// File: rtl/sd_crc16.sv
// CRC16-CCITT (0x1021, init 0, unreflected), one whole byte folded in per enabled cycle.
module sd_crc16
   import sd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q ^ {din, 8'h00};
      for (int i = 0; i < 8; i++) begin
         crc_d = crc_d[15] ? ((crc_d << 1) ^ CRC16_POLY) : (crc_d << 1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc_q <= '0;
      end else if (clr) begin
         crc_q <= '0;
      end else if (en) begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_block_reader.sv
// CMD17 single-block read sequencer: issues the command, hunts the start token,
// streams 512 payload bytes out with an index and checks the trailing CRC16.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for rd_req
// ST_ISSUE | cmd/address held, waiting for sd_rdy to pulse sd_en
// ST_RESP  | waiting for the R1 status strobe
// ST_TOKEN | hunting for 0xFE, down-counting the idle-byte budget
// ST_DATA  | forwarding 512 payload bytes into the CRC
// ST_CRC   | collecting the two CRC bytes, MSB first
// ST_FIN   | rd_done pulse cycle; also accepts a new request
module sd_block_reader
   import sd_pkg::*;
#(
   parameter int ADDR_BYTE     = 0,
   parameter int TOKEN_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_req,
   input  logic [31:0] rd_sector,
   output logic        rd_busy,
   output logic        rd_done,
   output logic [2:0]  rd_err,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic [8:0]  byte_idx,
   output logic [6:0]  sd_cmd,
   output logic [31:0] sd_address,
   output logic        sd_en,
   input  logic        sd_rdy,
   input  logic        sd_valid_status,
   input  logic [6:0]  sd_resp_status,
   input  logic [7:0]  sd_data,
   input  logic        sd_data_valid
);

   localparam int              HW        = $clog2(TOKEN_TIMEOUT + 1);
   localparam logic [HW-1:0]   HUNT_LOAD = HW'(TOKEN_TIMEOUT - 1);

   state_t        state_q;
   logic          busy_q;
   logic          done_q;
   logic [2:0]    err_q;
   logic [7:0]    byte_q;
   logic          bvalid_q;
   logic [8:0]    bidx_q;
   logic [8:0]    idx_q;
   logic [6:0]    cmd_q;
   logic [31:0]   addr_q;
   logic          en_q;
   logic [HW-1:0] hunt_q;
   logic [7:0]    crc_hi_q;
   logic          crc_second_q;

   logic [31:0]   addr_w;
   logic          accept;
   logic          crc_clr;
   logic          crc_en;
   logic [15:0]   crc_val;

   assign addr_w  = (ADDR_BYTE != 0) ? {rd_sector[22:0], 9'd0} : rd_sector;
   // FIN is the rd_done cycle, so a request there is taken back-to-back
   assign accept  = rd_req && ((state_q == ST_IDLE) || (state_q == ST_FIN));
   assign crc_clr = (state_q == ST_TOKEN) && sd_data_valid && (sd_data == TOK_START);
   assign crc_en  = (state_q == ST_DATA) && sd_data_valid;

   sd_crc16 u_crc (
      .clk (clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (sd_data),
      .crc (crc_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= ERR_OK;
         byte_q       <= '0;
         bvalid_q     <= 1'b0;
         bidx_q       <= '0;
         idx_q        <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         en_q         <= 1'b0;
         hunt_q       <= '0;
         crc_hi_q     <= '0;
         crc_second_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         bvalid_q <= 1'b0;
         en_q     <= 1'b0;
         case (state_q)
            ST_IDLE, ST_FIN: begin
               state_q <= ST_IDLE;
               if (accept) begin
                  busy_q  <= 1'b1;
                  err_q   <= ERR_OK;
                  cmd_q   <= CMD17;
                  addr_q  <= addr_w;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sd_rdy) begin
                  en_q    <= 1'b1;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (sd_valid_status) begin
                  if (sd_resp_status == 7'd0) begin
                     hunt_q  <= HUNT_LOAD;
                     idx_q   <= '0;
                     state_q <= ST_TOKEN;
                  end else begin
                     err_q   <= ERR_R1;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_FIN;
                  end
               end
            end
            ST_TOKEN: begin
               if (sd_data_valid) begin
                  if (sd_data == TOK_START) begin
                     idx_q        <= '0;
                     crc_second_q <= 1'b0;
                     state_q      <= ST_DATA;
                  end else if (sd_data[7:4] == 4'h0) begin
                     err_q   <= ERR_DATA_TOK;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_FIN;
                  end else if (hunt_q == '0) begin
                     err_q   <= ERR_TIMEOUT;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_FIN;
                  end else begin
                     hunt_q <= hunt_q - 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (sd_data_valid) begin
                  byte_q   <= sd_data;
                  bidx_q   <= idx_q;
                  bvalid_q <= 1'b1;
                  idx_q    <= idx_q + 1'b1;
                  if (idx_q == 9'd511) begin
                     state_q <= ST_CRC;
                  end
               end
            end
            ST_CRC: begin
               if (sd_data_valid) begin
                  if (!crc_second_q) begin
                     crc_hi_q     <= sd_data;
                     crc_second_q <= 1'b1;
                  end else begin
                     err_q   <= ({crc_hi_q, sd_data} == crc_val) ? ERR_OK : ERR_CRC;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_FIN;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rd_busy    = busy_q;
   assign rd_done    = done_q;
   assign rd_err     = err_q;
   assign byte_out   = byte_q;
   assign byte_valid = bvalid_q;
   assign byte_idx   = bidx_q;
   assign sd_cmd     = cmd_q;
   assign sd_address = addr_q;
   assign sd_en      = en_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed bench for sd_block_reader: drives a behavioural SD controller side and
// checks command issue, payload forwarding, CRC result and every error path.
module tb_sd_block_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_req = 1'b0;
   logic [31:0] rd_sector = '0;
   logic        rd_busy;
   logic        rd_done;
   logic [2:0]  rd_err;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic [8:0]  byte_idx;
   logic [6:0]  sd_cmd;
   logic [31:0] sd_address;
   logic        sd_en;
   logic        sd_rdy = 1'b0;
   logic        sd_valid_status = 1'b0;
   logic [6:0]  sd_resp_status = '0;
   logic [7:0]  sd_data = '0;
   logic        sd_data_valid = 1'b0;

   always #5 clk = ~clk;

   sd_block_reader #(.ADDR_BYTE(1), .TOKEN_TIMEOUT(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .rd_req          (rd_req),
      .rd_sector       (rd_sector),
      .rd_busy         (rd_busy),
      .rd_done         (rd_done),
      .rd_err          (rd_err),
      .byte_out        (byte_out),
      .byte_valid      (byte_valid),
      .byte_idx        (byte_idx),
      .sd_cmd          (sd_cmd),
      .sd_address      (sd_address),
      .sd_en           (sd_en),
      .sd_rdy          (sd_rdy),
      .sd_valid_status (sd_valid_status),
      .sd_resp_status  (sd_resp_status),
      .sd_data         (sd_data),
      .sd_data_valid   (sd_data_valid)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         en_cnt   = 0;
   int         bv_cnt   = 0;
   int         done_cnt = 0;
   int         idx_errs = 0;
   int         data_errs = 0;
   logic [8:0] exp_idx  = '0;
   logic [7:0] exp_data [512];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst || !rd_busy) exp_idx <= '0;
      if (sd_en) en_cnt++;
      if (rd_done) done_cnt++;
      if (byte_valid) begin
         bv_cnt++;
         if (byte_idx !== exp_idx) idx_errs++;
         if (byte_out !== exp_data[exp_idx]) data_errs++;
         exp_idx <= exp_idx + 9'd1;
      end
   end

   // Bit-serial reference, deliberately a different formulation from the RTL
   function automatic logic [15:0] crc_model();
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 0; i < 512; i++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ exp_data[i][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      sd_data       = b;
      sd_data_valid = 1'b1;
      tick();
      sd_data_valid = 1'b0;
   endtask

   task automatic request(input logic [31:0] sector, input bit hold);
      rd_sector = sector;
      rd_req    = 1'b1;
      tick();
      if (!hold) rd_req = 1'b0;
      check("busy_after_req", rd_busy, 1'b1);
   endtask

   task automatic wait_en(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (sd_en) seen = 1'b1;
      end
      check(tag, seen, 1'b1);
   endtask

   task automatic give_r1(input logic [6:0] r);
      tick();
      sd_resp_status  = r;
      sd_valid_status = 1'b1;
      tick();
      sd_valid_status = 1'b0;
   endtask

   task automatic send_payload(input logic [15:0] crc_sent, input logic [2:0] exp_err,
                               input string tag);
      int bvb;
      bvb = bv_cnt;
      put(exp_data[0]);
      check({tag, "_bv_latency"}, {byte_valid, byte_idx, byte_out}, {1'b1, 9'd0, exp_data[0]});
      for (int i = 1; i < 512; i++) put(exp_data[i]);
      put(crc_sent[15:8]);
      put(crc_sent[7:0]);
      check({tag, "_done_err"}, {rd_done, rd_busy, rd_err}, {1'b1, 1'b0, exp_err});
      tick();
      check({tag, "_byte_count"}, bv_cnt - bvb, 512);
      check({tag, "_idx_data_errs"}, {idx_errs, data_errs}, 64'd0);
   endtask

   initial begin
      int base_en;
      int base_bv;
      int base_done;
      logic [15:0] crc;

      repeat (3) tick();
      check("reset_outputs",
            {rd_busy, rd_done, rd_err, byte_out, byte_valid, byte_idx, sd_cmd, sd_address, sd_en},
            64'd0);
      rst = 1'b1;
      tick();

      // Test 1: all-0xFF block, card not ready at first
      for (int i = 0; i < 512; i++) exp_data[i] = 8'hFF;
      crc     = crc_model();
      base_en = en_cnt;
      request(32'h5, 1'b0);
      repeat (3) tick();
      check("no_en_while_not_rdy", en_cnt - base_en, 0);
      sd_rdy = 1'b1;
      wait_en("t1_en_seen");
      check("t1_cmd", sd_cmd, 7'd17);
      check("t1_addr", sd_address, 32'h0000_0A00);
      give_r1(7'h00);
      put(8'hFF); put(8'hFF); put(8'hFF); put(8'hFE);
      send_payload(crc, 3'd0, "t1");
      check("t1_single_en", en_cnt - base_en, 1);

      // Test 2: corrupted CRC low byte
      base_en = en_cnt;
      request(32'h5, 1'b0);
      wait_en("t2_en_seen");
      give_r1(7'h00);
      put(8'hFE);
      send_payload(crc ^ 16'h0001, 3'd4, "t2");

      // Test 3: R1 error status
      base_en = en_cnt;
      base_bv = bv_cnt;
      request(32'h7, 1'b0);
      wait_en("t3_en_seen");
      give_r1(7'h04);
      check("t3_done_err", {rd_done, rd_busy, rd_err}, {1'b1, 1'b0, 3'd1});
      repeat (10) tick();
      check("t3_no_extra_en_no_bytes", {en_cnt - base_en, bv_cnt - base_bv}, {32'd1, 32'd0});

      // Test 4: token timeout after the 16th idle byte
      base_done = done_cnt;
      request(32'h9, 1'b0);
      wait_en("t4_en_seen");
      give_r1(7'h00);
      for (int i = 0; i < 15; i++) put(8'hFF);
      check("t4_not_yet_timed_out", {rd_busy, done_cnt - base_done}, {1'b1, 32'd0});
      put(8'hFF);
      check("t4_done_err", {rd_done, rd_err}, {1'b1, 3'd2});
      tick();

      // Test 5: data error token
      request(32'h9, 1'b0);
      wait_en("t5_en_seen");
      give_r1(7'h00);
      put(8'hFF);
      put(8'h08);
      check("t5_done_err", {rd_done, rd_err}, {1'b1, 3'd3});
      tick();

      // Test 6: rd_req held through busy, then reset in the middle of the data phase
      for (int i = 0; i < 512; i++) exp_data[i] = 8'((i * 7 + 3) ^ (i >> 3));
      crc       = crc_model();
      base_en   = en_cnt;
      base_done = done_cnt;
      request(32'h0012_3456, 1'b1);
      wait_en("t6_en_seen");
      give_r1(7'h00);
      put(8'hFE);
      for (int i = 0; i < 100; i++) put(exp_data[i]);
      repeat (5) tick();
      check("t6_one_en_held_req", en_cnt - base_en, 1);
      rst = 1'b0;
      #1;
      rd_req = 1'b0;
      check("t6_reset_outputs",
            {rd_busy, rd_done, rd_err, byte_out, byte_valid, byte_idx, sd_cmd, sd_address, sd_en},
            64'd0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      check("t6_no_done_after_reset", {rd_busy, done_cnt - base_done}, {1'b0, 32'd0});

      base_en = en_cnt;
      request(32'h0012_3456, 1'b0);
      wait_en("t6b_en_seen");
      check("t6b_addr", sd_address, 32'h2468_AC00);
      give_r1(7'h00);
      put(8'hC3);
      put(8'hFE);
      send_payload(crc, 3'd0, "t6b");
      check("t6b_single_en", en_cnt - base_en, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
